alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 28 ++
 rtl/alu_arbiter_picker.sv | 32 +++
 rtl/alu_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared ISA types for the ALU arbiter: op codes, the ALU request struct and
// the arbiter state encoding.
package Isa;

    localparam int REGISTER_SIZE = 32;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4
    } OpCode;

    typedef struct packed {
        OpCode                    op_code;
        logic [REGISTER_SIZE-1:0] a;
        logic [REGISTER_SIZE-1:0] b;
    } AluRequest;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_WAIT    = 2'd2,
        ARB_RESPOND = 2'd3
    } ArbState;

endpackage

// File: rtl/alu_arbiter_picker.sv
// Combinational round-robin search: first valid client after last_grant,
// wrapping from N-1 back to 0.
module round_robin_picker #(
    parameter int N    = 4,
    parameter int IdxW = $clog2(N)
) (
    input  logic [N-1:0]    valid_i,
    input  logic [IdxW-1:0] last_grant_i,
    output logic [IdxW-1:0] grant_o,
    output logic            any_valid_o
);

    logic [IdxW:0] cand;

    // Scan farthest-first so the nearest valid client after last_grant wins.
    always_comb begin
        grant_o     = last_grant_i;
        any_valid_o = 1'b0;
        cand        = '0;
        for (int k = N; k >= 1; k--) begin
            cand = {1'b0, last_grant_i} + (IdxW+1)'(k);
            if (cand >= (IdxW+1)'(N)) begin
                cand = cand - (IdxW+1)'(N);
            end
            if (valid_i[cand[IdxW-1:0]]) begin
                grant_o     = cand[IdxW-1:0];
                any_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among N clients, one operation in flight.
// Optional WAIT watchdog enabled by defining ALU_ARBITER_TIMEOUT_EN.
module alu_arbiter
    import Isa::*;
#(
    parameter int NumberOfRequesters = 4,
    parameter int TimeoutCycles      = 1024
) (
    input  logic                                i_clock,
    input  logic                                i_reset,
    input  logic      [NumberOfRequesters-1:0]  i_req_valid,
    input  AluRequest [NumberOfRequesters-1:0]  i_req,
    output logic      [NumberOfRequesters-1:0]  o_req_ready,
    output logic      [NumberOfRequesters-1:0]  o_rsp_valid,
    output logic      [REGISTER_SIZE-1:0]       o_rsp_result,
    output logic                                o_rsp_error,
    output logic                                o_alu_valid,
    output AluRequest                           o_alu_req,
    input  logic                                i_alu_ready,
    input  logic                                i_alu_done,
    input  logic      [REGISTER_SIZE-1:0]       i_alu_result
);

    localparam int N    = NumberOfRequesters;
    localparam int IdxW = $clog2(N);

    if (N < 2 || N > 16 || TimeoutCycles < 1) begin : g_param_check
        $error("alu_arbiter: NumberOfRequesters must be 2..16 and TimeoutCycles >= 1");
    end

    function automatic logic [N-1:0] onehot(input logic [IdxW-1:0] idx);
        return {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

    ArbState                state_q;
    logic [IdxW-1:0]        last_grant_q;
    logic [IdxW-1:0]        grant_q;
    AluRequest              alu_req_q;
    logic                   alu_valid_q;
    logic [N-1:0]           rsp_valid_q;
    logic [REGISTER_SIZE-1:0] result_q;
    logic [IdxW-1:0]        pick;
    logic                   any_valid;
    logic [N-1:0]           req_ready_d;

`ifdef ALU_ARBITER_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0]        wait_cnt_q;
    logic                   error_q;
`endif

    round_robin_picker #(.N(N), .IdxW(IdxW)) u_picker (
        .valid_i      (i_req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (pick),
        .any_valid_o  (any_valid)
    );

    // Grant is offered combinationally in IDLE; a valid request is always accepted.
    always_comb begin
        req_ready_d = '0;
        if (state_q == ARB_IDLE && any_valid && !i_reset) begin
            req_ready_d = onehot(pick);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= IdxW'(N - 1);
            grant_q      <= '0;
            alu_req_q    <= '0;
            alu_valid_q  <= 1'b0;
            rsp_valid_q  <= '0;
            result_q     <= '0;
`ifdef ALU_ARBITER_TIMEOUT_EN
            wait_cnt_q   <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (any_valid) begin
                        alu_req_q    <= i_req[pick];
                        grant_q      <= pick;
                        last_grant_q <= pick;
                        alu_valid_q  <= 1'b1;
                        state_q      <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (i_alu_ready) begin
                        alu_valid_q <= 1'b0;
                        state_q     <= ARB_WAIT;
`ifdef ALU_ARBITER_TIMEOUT_EN
                        wait_cnt_q  <= '0;
`endif
                    end
                end
                ARB_WAIT: begin
                    // A done on the limit cycle takes precedence over the timeout.
                    if (i_alu_done) begin
                        result_q    <= i_alu_result;
                        rsp_valid_q <= onehot(grant_q);
                        state_q     <= ARB_RESPOND;
`ifdef ALU_ARBITER_TIMEOUT_EN
                        error_q     <= 1'b0;
                    end else if (wait_cnt_q == CntW'(TimeoutCycles - 1)) begin
                        result_q    <= '0;
                        error_q     <= 1'b1;
                        rsp_valid_q <= onehot(grant_q);
                        state_q     <= ARB_RESPOND;
                    end else begin
                        wait_cnt_q  <= wait_cnt_q + 1'b1;
`endif
                    end
                end
                ARB_RESPOND: begin
                    rsp_valid_q <= '0;
                    state_q     <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign o_req_ready  = req_ready_d;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_result = result_q;
    assign o_alu_valid  = alu_valid_q;
    assign o_alu_req    = alu_req_q;
`ifdef ALU_ARBITER_TIMEOUT_EN
    assign o_rsp_error  = error_q;
`else
    assign o_rsp_error  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level model.
// Define ALU_ARBITER_TIMEOUT_EN to also exercise the WAIT watchdog.
module tb_alu_arbiter;
    import Isa::*;

`ifdef ALU_ARBITER_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      vld = '0;
    AluRequest [3:0] req = '0;
    logic [3:0]      rdy_o, rspv_o;
    logic [31:0]     res_o;
    logic            err_o, aluv_o;
    AluRequest       alureq_o;
    logic            alu_rdy = 1'b0, alu_done = 1'b0;
    logic [31:0]     alu_res = '0;

    int checks = 0, failures = 0;
    int rdy_p = 100, done_p = 100, spur_p = 0;

    int          grant_log[$];
    int          rsp_client_log[$];
    logic [31:0] rsp_res_log[$];

    alu_arbiter #(.NumberOfRequesters(4), .TimeoutCycles(TO)) dut (
        .i_clock(clk), .i_reset(rst), .i_req_valid(vld), .i_req(req),
        .o_req_ready(rdy_o), .o_rsp_valid(rspv_o), .o_rsp_result(res_o),
        .o_rsp_error(err_o), .o_alu_valid(aluv_o), .o_alu_req(alureq_o),
        .i_alu_ready(alu_rdy), .i_alu_done(alu_done), .i_alu_result(alu_res)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] alu_ref(AluRequest r);
        case (r.op_code)
            OP_ADD:  return r.a + r.b;
            OP_SUB:  return r.a - r.b;
            OP_AND:  return r.a & r.b;
            OP_OR:   return r.a | r.b;
            OP_XOR:  return r.a ^ r.b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic OpCode op_of(int k);
        case (k)
            0: return OP_ADD;
            1: return OP_SUB;
            2: return OP_AND;
            3: return OP_OR;
            default: return OP_XOR;
        endcase
    endfunction

    function automatic int pick(logic [3:0] v, int last);
        for (int k = 1; k <= 4; k++) if (v[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    // Transaction-level model: one operation at a time, tracked by its handshakes.
    bit          busy = 0, alu_taken = 0, rsp_due = 0, exp_err = 0;
    int          last_grant = 3, exp_client = 0, wait_n = 0, busy_cyc = 0;
    AluRequest   exp_req = '0;
    logic [31:0] exp_res = '0, last_result = '0;

    initial begin
        logic [3:0] exp_ready, exp_rspv;
        int p;
        forever begin
            @(negedge clk);
            exp_ready = '0;
            p = pick(vld, last_grant);
            if (!rst && !busy && p >= 0) exp_ready = 4'b1 << p;
            chk("req_ready", rdy_o, exp_ready);
            exp_rspv = rsp_due ? (4'b1 << exp_client) : 4'b0;
            chk("rsp_valid", rspv_o, exp_rspv);
            if (rsp_due) begin
                chk("rsp_result", res_o, exp_res);
                chk("rsp_error", err_o, exp_err);
            end else begin
                chk("rsp_result_hold", res_o, last_result);
            end
            chk("alu_valid", aluv_o, busy && !alu_taken);
            if (busy && !alu_taken) chk("alu_req", alureq_o, exp_req);

            if (rst) begin
                busy = 0; alu_taken = 0; rsp_due = 0; last_grant = 3; last_result = '0;
            end else if (rsp_due) begin
                rsp_due = 0; busy = 0; last_result = exp_res;
                rsp_client_log.push_back(exp_client);
                rsp_res_log.push_back(exp_res);
            end else if (busy) begin
                busy_cyc++;
                if (busy_cyc > 2000) begin
                    checks++; failures++;
                    $display("FAIL op_watchdog: client %0d got no response in %0d cycles", exp_client, busy_cyc);
                    busy = 0;
                end else if (!alu_taken) begin
                    if (alu_rdy) begin alu_taken = 1; wait_n = 0; end
                end else if (alu_done) begin
                    rsp_due = 1;
                end else begin
                    wait_n++;
`ifdef ALU_ARBITER_TIMEOUT_EN
                    if (wait_n == TO) begin rsp_due = 1; exp_err = 1; exp_res = '0; end
`endif
                end
            end else if (exp_ready != 0) begin
                busy = 1; alu_taken = 0; exp_err = 0; busy_cyc = 0;
                exp_client = p; last_grant = p;
                exp_req = req[p]; exp_res = alu_ref(req[p]);
                grant_log.push_back(p);
            end
        end
    end

    // ALU side: computes on what it receives; may strobe done spuriously when idle.
    initial begin
        bit        has_op = 0;
        AluRequest op = '0;
        forever begin
            @(negedge clk);
            if (rst) has_op = 0;
            else if (!has_op && aluv_o && alu_rdy) begin has_op = 1; op = alureq_o; end
            else if (has_op && alu_done) has_op = 0;
            @(posedge clk); #2;
            alu_rdy = $urandom_range(0, 99) < rdy_p;
            if (has_op) begin
                alu_done = $urandom_range(0, 99) < done_p;
                alu_res  = alu_done ? alu_ref(op) : $urandom;
            end else begin
                alu_done = $urandom_range(0, 99) < spur_p;
                alu_res  = $urandom;
            end
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask

    task automatic do_reset();
        rst = 1; vld = '0;
        tick(); tick();
        rst = 0;
        grant_log.delete(); rsp_client_log.delete(); rsp_res_log.delete();
    endtask

    task automatic set_req(int c, OpCode op, logic [31:0] a, logic [31:0] b);
        req[c].op_code = op; req[c].a = a; req[c].b = b; vld[c] = 1'b1;
    endtask

    task automatic wait_grant(int c);
        int n = 0;
        do begin @(negedge clk); n++; end while (!rdy_o[c] && n < 200);
        if (!rdy_o[c]) begin
            checks++; failures++;
            $display("FAIL grant_timeout: client %0d not granted, ready=%b", c, rdy_o);
        end
        tick();
        vld[c] = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (rspv_o == '0 && n < 200);
        if (rspv_o == '0) begin
            checks++; failures++;
            $display("FAIL rsp_timeout: no response after %0d cycles, required one", n);
        end
    endtask

    initial begin
        int n;
        logic [3:0] acc;
        // Reset state, with every client requesting during reset.
        rst = 1; vld = 4'hF;
        tick(); tick();
        @(negedge clk);
        chk("reset_ready", rdy_o, 4'h0);
        chk("reset_rsp_valid", rspv_o, 4'h0);
        chk("reset_result", res_o, 32'h0);
        chk("reset_error", err_o, 1'b0);
        chk("reset_alu_valid", aluv_o, 1'b0);
        chk("reset_alu_req", alureq_o, '0);

        // Client 0 before client 2 after reset.
        do_reset();
        set_req(0, OP_ADD, 32'd5, 32'd3);
        set_req(2, OP_SUB, 32'd9, 32'd4);
        wait_grant(0);
        wait_grant(2);
        repeat (6) tick();
        chk("t1_rsp_count", rsp_client_log.size(), 2);
        chk("t1_first_client", rsp_client_log[0], 0);
        chk("t1_first_result", rsp_res_log[0], 32'd8);
        chk("t1_second_client", rsp_client_log[1], 2);
        chk("t1_second_result", rsp_res_log[1], 32'd5);

        // All four clients requesting continuously.
        do_reset();
        for (int c = 0; c < 4; c++) set_req(c, op_of(c), 32'(c * 7 + 1), 32'(c + 2));
        n = 0;
        while (grant_log.size() < 8 && n < 300) begin tick(); n++; end
        vld = '0;
        chk("t2_grant_count", grant_log.size(), 8);
        for (int k = 0; k < 8; k++) chk("t2_grant_order", grant_log[k], k % 4);
        repeat (8) tick();

        // ALU holds off acceptance for 10 cycles.
        do_reset();
        rdy_p = 0;
        set_req(1, OP_OR, 32'h12, 32'h21);
        wait_grant(1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t3_hold_alu_valid", aluv_o, 1'b1);
            chk("t3_hold_alu_req", alureq_o, {OP_OR, 32'h12, 32'h21});
        end
        rdy_p = 100;
        wait_rsp(n);
        chk("t3_result", res_o, 32'h33);
        chk("t3_client", rspv_o, 4'b0010);
        tick();

        // Reset while in WAIT, then a late done.
        do_reset();
        done_p = 0;
        set_req(3, OP_ADD, 32'd1, 32'd2);
        wait_grant(3);
        repeat (3) tick();
        rst = 1; tick(); rst = 0;
        spur_p = 100; repeat (3) tick();
        spur_p = 0; repeat (2) tick();
        chk("t4_no_response", rsp_client_log.size(), 0);
        chk("t4_idle_alu_valid", aluv_o, 1'b0);
        done_p = 100;
        set_req(1, OP_SUB, 32'd10, 32'd3);
        wait_grant(1);
        wait_rsp(n);
        chk("t4_min_latency", n, 3);
        chk("t4_result", res_o, 32'd7);
        chk("t4_client", rspv_o, 4'b0010);
        tick();

        // Spurious done while in ISSUE.
        do_reset();
        rdy_p = 0; spur_p = 100;
        set_req(2, OP_AND, 32'hF0, 32'h3C);
        wait_grant(2);
        repeat (3) tick();
        spur_p = 0; rdy_p = 100;
        wait_rsp(n);
        chk("t5_result", res_o, 32'h30);
        chk("t5_client", rspv_o, 4'b0100);
        tick();

`ifdef ALU_ARBITER_TIMEOUT_EN
        // ALU never finishes: watchdog answers with an error.
        do_reset();
        done_p = 0;
        set_req(0, OP_XOR, 32'hAA, 32'h55);
        wait_grant(0);
        wait_rsp(n);
        chk("t6_timeout_cycle", n, TO + 2);
        chk("t6_error", err_o, 1'b1);
        chk("t6_result", res_o, 32'h0);
        done_p = 100;
        tick();
`endif

        // Randomized traffic with random ALU timing and occasional resets.
        do_reset();
        rdy_p = 60; done_p = 40; spur_p = 20;
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            acc = rdy_o;
            tick();
            rst = ($urandom_range(0, 299) == 0);
            for (int c = 0; c < 4; c++) begin
                if (acc[c] || !vld[c]) begin
                    vld[c] = ($urandom_range(0, 2) == 0);
                    req[c].op_code = op_of($urandom_range(0, 4));
                    req[c].a = $urandom;
                    req[c].b = $urandom;
                end
            end
        end
        rst = 0; vld = '0;
        rdy_p = 100; done_p = 100; spur_p = 0;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
